// File: rtl/echo_fx.sv
// Stereo echo stage: a block-RAM ring buffer replays each frame delay_len frames later.
// Repeats decay through a feedback term on the write path; output latency is 4 cycles.
package sample_pkg;
  typedef struct packed {
    logic [23:0] lc;
    logic [23:0] rc;
  } sample_t;
endpackage

module echo_fx #(
  parameter int ADDR_W = 14
) (
  input  logic                 mclk,
  input  logic                 rst,
  input  sample_pkg::sample_t  in_data,
  input  logic                 in_vld,
  input  logic [ADDR_W-1:0]    delay_len,
  input  logic [7:0]           feedback,
  input  logic [7:0]           mix,
  input  logic                 bypass,
  output sample_pkg::sample_t  out_data,
  output logic                 out_vld
);
  typedef enum logic [2:0] {IDLE, RD, WAIT, CALC, WB} state_t;

  state_t              state_reg, state_next;
  logic [47:0]         x_reg;
  logic [ADDR_W-1:0]   delay_reg, wr_ptr_reg, rd_addr;
  logic [7:0]          fb_reg, mix_reg;
  logic                byp_reg;
  logic [ADDR_W:0]     fill_reg, fill_cap_reg;
  logic [47:0]         mem [2**ADDR_W];
  logic [47:0]         rd_data_reg;
  logic [47:0]         y_word, w_word, out_reg;
  logic                zero_d, wb_fire;

  function automatic logic [23:0] sat24(input logic signed [25:0] s);
    if (s > 26'sh07FFFFF)       return 24'h7FFFFF;
    else if (s < -26'sh0800000) return 24'h800000;
    else                        return s[23:0];
  endfunction

  always_ff @(posedge mclk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_vld) state_next = RD;
      RD:      state_next = WAIT;
      WAIT:    state_next = CALC;
      CALC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A reset arriving during WB kills the frame: no pulse, no RAM write.
  always_comb begin
    wb_fire  = (state_reg == WB) && !rst;
    out_vld  = wb_fire;
    out_data = wb_fire ? y_word : out_reg;
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      fill_reg   <= '0;
      out_reg    <= '0;
    end else begin
      if (state_reg == IDLE && in_vld) begin
        x_reg        <= in_data;
        delay_reg    <= delay_len;
        fb_reg       <= feedback;
        mix_reg      <= mix;
        byp_reg      <= bypass;
        fill_cap_reg <= fill_reg;
      end
      if (wb_fire) begin
        out_reg    <= y_word;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (!fill_reg[ADDR_W]) fill_reg <= fill_reg + 1'b1;
      end
    end
  end

  assign rd_addr = wr_ptr_reg - delay_reg;
  // Locations not yet written since reset read as silence.
  assign zero_d  = (delay_reg == '0) || ({1'b0, delay_reg} > fill_cap_reg);

  always_ff @(posedge mclk) begin
    if (wb_fire) mem[wr_ptr_reg] <= w_word;
    rd_data_reg <= mem[rd_addr];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    localparam int LO = 24 * (1 - gi);
    logic [23:0] x_ch, d_reg;
    logic [24:0] pm_reg, pf_reg;
    logic [32:0] d_ext, pm_full, pf_full;
    logic [25:0] ysum, wsum;

    assign x_ch    = x_reg[LO +: 24];
    assign d_ext   = {{9{d_reg[23]}}, d_reg};
    // Low 33 bits of the product match the signed 24x9 result; dropping 8 bits floors.
    assign pm_full = d_ext * {25'b0, mix_reg};
    assign pf_full = d_ext * {25'b0, fb_reg};

    always_ff @(posedge mclk) begin
      if (state_reg == WAIT) d_reg <= zero_d ? '0 : rd_data_reg[LO +: 24];
      if (state_reg == CALC) begin
        pm_reg <= pm_full[32:8];
        pf_reg <= pf_full[32:8];
      end
    end

    assign ysum = {{2{x_ch[23]}}, x_ch} + {pm_reg[24], pm_reg};
    assign wsum = {{2{x_ch[23]}}, x_ch} + {pf_reg[24], pf_reg};
    assign y_word[LO +: 24] = byp_reg ? x_ch : sat24($signed(ysum));
    assign w_word[LO +: 24] = byp_reg ? x_ch : sat24($signed(wsum));
  end
endmodule

// File: tb/tb_echo_fx.sv
// Randomized + directed bench for echo_fx against a frame-level echo model.
module tb_echo_fx;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  sample_pkg::sample_t in_data = '0;
  logic in_vld = 1'b0;
  logic [AW-1:0] delay_len = '0;
  logic [7:0] feedback = '0, mix = '0;
  logic bypass = 1'b0;
  sample_pkg::sample_t out_data;
  logic out_vld;

  echo_fx #(.ADDR_W(AW)) dut (
    .mclk(clk), .rst(rst), .in_data(in_data), .in_vld(in_vld), .delay_len(delay_len),
    .feedback(feedback), .mix(mix), .bypass(bypass), .out_data(out_data), .out_vld(out_vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  typedef struct { int due; logic [47:0] y; } exp_t;
  exp_t q[$];
  logic [47:0] held = '0;
  logic [47:0] obs[$];
  int obs_cyc[$];
  int last_t;

  // Frame-level model: history of everything written, indexed by frame number since reset.
  int hl[$], hr[$];
  int nfr = 0;

  function automatic int sx(logic [23:0] v);
    return int'($signed(v));
  endfunction

  function automatic int sat(int s);
    if (s > 8388607) return 8388607;
    if (s < -8388608) return -8388608;
    return s;
  endfunction

  task automatic model_reset();
    hl.delete(); hr.delete(); nfr = 0;
  endtask

  task automatic model_frame(input int xl, xr, dl, fb, mx, input bit byp, output logic [47:0] y);
    int fm, dlv, drv, yl, yr;
    fm = (nfr < DEPTH) ? nfr : DEPTH;
    dlv = 0; drv = 0;
    if (dl != 0 && dl <= fm) begin
      dlv = hl[nfr - dl]; drv = hr[nfr - dl];
    end
    if (byp) begin
      yl = xl; yr = xr;
      hl.push_back(xl); hr.push_back(xr);
    end else begin
      yl = sat(xl + ((dlv * mx) >>> 8));
      yr = sat(xr + ((drv * mx) >>> 8));
      hl.push_back(sat(xl + ((dlv * fb) >>> 8)));
      hr.push_back(sat(xr + ((drv * fb) >>> 8)));
    end
    nfr++;
    y = {yl[23:0], yr[23:0]};
  endtask

  // Cycle-by-cycle check of out_vld/out_data against the scheduled expectations.
  always @(negedge clk) begin
    if (!rst) begin
      bit ev;
      if (q.size() > 0 && q[0].due < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL overdue: out_vld never rose at cycle %0d, required data %h", q[0].due, q[0].y);
        held = q[0].y;
        void'(q.pop_front());
      end
      ev = (q.size() > 0) && (q[0].due == cyc);
      n_cmp++;
      if (out_vld !== ev || out_data !== (ev ? q[0].y : held)) begin
        n_bad++;
        $display("FAIL cycle_check @%0d: out_vld=%b out_data=%h, required out_vld=%b out_data=%h",
                 cyc, out_vld, out_data, ev, ev ? q[0].y : held);
      end
      if (out_vld) begin
        obs.push_back(out_data); obs_cyc.push_back(cyc);
        $display("cycle %0d: out_vld data=%h", cyc, out_data);
      end
      if (ev) begin
        held = q[0].y;
        void'(q.pop_front());
      end
    end
  end

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic logic [47:0] ob(int k);
    if (k < obs.size()) return obs[k];
    return 'x;
  endfunction

  task automatic send(input logic [23:0] l, r, input int dl, fb, mx, input bit byp, extra, abrt);
    int t, g;
    logic [47:0] y;
    @(posedge clk); #1;
    in_data = {l, r}; delay_len = dl[AW-1:0]; feedback = fb[7:0]; mix = mx[7:0];
    bypass = byp; in_vld = 1'b1; t = cyc; last_t = t;
    if (!abrt) begin
      model_frame(sx(l), sx(r), dl, fb, mx, byp, y);
      q.push_back('{t + 4, y});
    end
    @(posedge clk); #1;
    // Inputs outside the pulse must not affect the frame in flight.
    in_vld = 1'b0;
    in_data = {24'($urandom()), 24'($urandom())};
    delay_len = AW'($urandom()); feedback = 8'($urandom()); mix = 8'($urandom());
    bypass = 1'($urandom());
    if (extra || abrt) begin
      @(posedge clk); #1;
      if (extra) in_vld = 1'b1;
      if (abrt) rst = 1'b1;
      @(posedge clk); #1;
      in_vld = 1'b0;
      if (abrt) begin
        rst = 1'b0; model_reset(); held = '0;
      end
    end
    g = $urandom_range(0, 3);
    while (cyc < t + 4 + g) begin @(posedge clk); #1; end
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    settle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset(); held = '0; q.delete(); obs.delete(); obs_cyc.delete();
  endtask

  logic [23:0] in_l [64];
  logic [23:0] in_r [64];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] rq;
    int v;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {out_vld, out_data}, 49'h0);

    // Latency with bypass
    send(24'h123456, 24'h654321, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("bypass_data", ob(0), 48'h123456_654321);
    chk("latency", (obs_cyc.size() > 0) ? 48'(obs_cyc[0] - last_t) : 'x, 48'd4);

    // Impulse echo
    do_reset();
    for (int k = 0; k < 34; k++)
      send((k == 0) ? 24'h100000 : 24'h0, 24'h0, 10, 8'h80, 8'hFF, 1'b0, 1'b0, 1'b0);
    settle();
    chk("impulse_f0",  ob(0),  {24'h100000, 24'h0});
    chk("impulse_f5",  ob(5),  48'h0);
    chk("impulse_f10", ob(10), {24'h0FF000, 24'h0});
    chk("impulse_f20", ob(20), {24'h07F800, 24'h0});
    chk("impulse_f30", ob(30), {24'h03FC00, 24'h0});
    chk("impulse_f31", ob(31), 48'h0);

    // Saturation, both rails
    do_reset();
    for (int k = 0; k < 6; k++) send(24'h7FFFFF, 24'h7FFFFF, 1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    settle();
    chk("sat_pos_f0", ob(0), 48'h7FFFFF_7FFFFF);
    chk("sat_pos_f5", ob(5), 48'h7FFFFF_7FFFFF);
    do_reset();
    for (int k = 0; k < 6; k++) send(24'h800000, 24'h800000, 1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    settle();
    chk("sat_neg_f1", ob(1), 48'h800000_800000);
    chk("sat_neg_f5", ob(5), 48'h800000_800000);

    // Floor of negative product
    do_reset();
    send(24'hFFFFFF, 24'hFFFFFF, 1, 0, 8'h80, 1'b0, 1'b0, 1'b0);
    send(24'h0, 24'h0, 1, 0, 8'h80, 1'b0, 1'b0, 1'b0);
    settle();
    chk("floor_f1", ob(1), 48'hFFFFFF_FFFFFF);

    // Fill guard hides stale RAM contents after reset
    do_reset();
    for (int k = 0; k < 15; k++) begin
      in_l[k] = 24'($urandom()); in_r[k] = 24'($urandom());
      send(in_l[k], in_r[k], 15, $urandom_range(0, 255), 8'hFF, 1'b0, 1'b0, 1'b0);
    end
    settle();
    for (int k = 0; k < 15; k++) chk("fill_guard", ob(k), {in_l[k], in_r[k]});

    // Disabled echo, then wrap-around with delay 15 over a signed ramp
    do_reset();
    for (int k = 0; k < 4; k++) send(24'h0ABCDE, 24'h012345, 0, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    settle();
    chk("delay0_f3", ob(3), 48'h0ABCDE_012345);
    do_reset();
    for (int k = 0; k < 40; k++) begin
      v = k * 32'h10001 - 32'h100000;
      in_l[k] = v[23:0]; in_r[k] = 24'(-v);
      send(in_l[k], in_r[k], 15, 0, 8'hC0, 1'b0, 1'b0, 1'b0);
    end
    settle();
    for (int k = 15; k < 40; k += 6) begin
      int el, er;
      el = sx(in_l[k]) + ((sx(in_l[k-15]) * 192) >>> 8);
      er = sx(in_r[k]) + ((sx(in_r[k-15]) * 192) >>> 8);
      rq = {el[23:0], er[23:0]};
      chk("wrap", ob(k), rq);
    end

    // Busy drop: second pulse at T+2 is ignored, so the next frame reads frame A
    do_reset();
    send(24'h010000, 24'h020000, 1, 0, 8'hFF, 1'b0, 1'b1, 1'b0);
    send(24'h0, 24'h0, 1, 0, 8'hFF, 1'b0, 1'b0, 1'b0);
    settle();
    chk("busy_count", 48'(obs.size()), 48'd2);
    chk("busy_read", ob(1), {24'h00FF00, 24'h01FE00});

    // Reset mid-frame: no output, and the next frame sees fill = 0
    do_reset();
    send(24'h200000, 24'h200000, 1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    send(24'h000100, 24'h000200, 1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    settle();
    chk("abort_count", 48'(obs.size()), 48'd1);
    chk("abort_next", ob(0), {24'h000100, 24'h000200});

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 300; k++)
      send(24'($urandom()), 24'($urandom()), $urandom_range(0, DEPTH - 1), $urandom_range(0, 255),
           $urandom_range(0, 255), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), 1'b0);
    settle();
    chk("random_drain", 48'(q.size()), 48'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/echo_fx.md
# echo_fx

Stereo echo/delay effect stage that sits directly downstream of the I2S receiver and directly upstream of the I2S transmitter in the pedal datapath. It accepts one stereo sample per frame (`in_vld` pulse), stores it in a block-RAM ring buffer, and mixes in the sample from `delay_len` frames earlier. The buffer write path carries a feedback term, so each repeat decays. It emits one processed stereo sample per input with a fixed 4-cycle latency.

## Interface
Parameters:
- `ADDR_W`, default 14: ring buffer depth is 2^ADDR_W frames (16384 ≈ 371 ms at 44.1 kHz).

Ports:
- `mclk` in, 1: sole clock, 22.579 MHz audio master clock.
- `rst` in, 1: synchronous, active-high reset.
- `in_data` in, `sample_pkg::sample_t`: `.lc`/`.rc` are 24-bit two's-complement; valid only while `in_vld` is high.
- `in_vld` in, 1: single-cycle pulse, one per frame, nominally 512 `mclk` apart.
- `delay_len` in, ADDR_W: echo delay in frames. 0 disables the echo term.
- `feedback` in, 8: unsigned Q0.8 gain on the delayed sample in the write path.
- `mix` in, 8: unsigned Q0.8 gain on the delayed sample in the output path.
- `bypass` in, 1: 1 makes output equal input.
- `out_data` out, `sample_pkg::sample_t`: processed sample. Held stable between `out_vld` pulses.
- `out_vld` out, 1: single-cycle pulse; connects directly to the transmitter's `tx_vld`.

## Operation
- Memory: one 2^ADDR_W × 48-bit simple-dual-port RAM holding `{lc, rc}`, with 1-cycle registered read. Contents are never cleared.
- Write pointer `wr_ptr` (ADDR_W bits): reset 0, increments by 1 per accepted frame, wraps 2^ADDR_W−1 → 0.
- Fill counter `fill` (ADDR_W+1 bits): reset 0, increments per accepted frame, saturates at 2^ADDR_W.
- Read address: `rd_addr = (wr_ptr − delay_len) mod 2^ADDR_W`.
- Delayed sample `d` is forced to 0 if `delay_len == 0` or `delay_len > fill`. This hides stale RAM contents after reset.
- FSM states and transitions: IDLE → RD → WAIT → CALC → WB → IDLE.
  - IDLE: on `in_vld`, capture `in_data`, `delay_len`, `feedback`, `mix`, `bypass`, and `fill`; go to RD. Config changes at any other time have no effect on the frame in flight.
  - RD: present `rd_addr` to the RAM.
  - WAIT: RAM data becomes valid; register it as `d`, with the forcing rule applied.
  - CALC: register products `pm = d*{0,mix}` and `pf = d*{0,feedback}`. Each is a 24×9 signed multiply producing 33 bits, then arithmetic shift right 8 (floor, not round).
  - WB: compute per channel:
    - `y = sat24(x + pm)`
    - `w = sat24(x + pf)`
    - Write `w` at `wr_ptr`, load `out_data = y`, pulse `out_vld`, increment `wr_ptr` and `fill`.
- Bypass: `y = x` and `w = x`; the buffer keeps recording so the echo resumes cleanly when bypass is released.
- `sat24`: sum is computed at 26 bits signed, then clamped to [−2^23, 2^23−1] (0x800000..0x7FFFFF).
- `in_vld` while the FSM is not in IDLE: the pulse is dropped and there is no state change. This cannot occur at the nominal frame rate.

## Timing
- In-vld at cycle T → out_vld high exactly at cycle T+4, for exactly one cycle. `out_data` updates in the same cycle as `out_vld`.
- RAM write occurs in cycle T+4. A later frame with `delay_len = 1` reads it correctly, since its read happens at least 5 cycles later.
- Reset values: `out_data.lc = out_data.rc = 0`, `out_vld = 0`, FSM = IDLE, `wr_ptr = 0`, `fill = 0`.
- Reset mid-operation (any state): in the next cycle the FSM is IDLE. No `out_vld` is generated and no RAM write occurs for the aborted frame.
- Throughput: one frame per 5 cycles maximum; the nominal rate is 1 per 512.

## Test plan
- **Latency/reset:** release `rst`, pulse `in_vld` with lc=0x123456, rc=0x654321, `bypass`=1 → `out_vld` exactly 4 cycles later with identical data. Before the first pulse, `out_data` = 0 and `out_vld` = 0.
- **Impulse echo:** `delay_len`=10, `feedback`=0x80, `mix`=0xFF; feed lc=0x100000 at frame 0, then zeros, 512 cycles apart → expected outputs:
  - frame 0: 0x100000
  - frame 10: 0x0FF000
  - frame 20: 0x07F800
  - frame 30: 0x03FC00
  - all other frames: 0
- **Saturation:** `delay_len`=1, `feedback`=`mix`=0xFF, constant input 0x7FFFFF → frame 0 = 0x7FFFFF, all later frames = 0x7FFFFF. Repeating with 0x800000 gives 0x800000 on every frame.
- **Floor and fill guard:** after reset, `delay_len`=100, `mix`=0xFF, with RAM preloaded with garbage → frames 0–99 out = in exactly. With `delay_len`=1, `mix`=0x80, input −1 then 0 → frame 1 output = 0xFFFFFF (−1).
- **Wrap-around:** `ADDR_W`=4, `delay_len`=16 (passed as 0 → disabled, check out = in), then `delay_len`=15, run 40 frames of a ramp → each output = in + floor(in[n−15]·mix/256). Confirms correct addressing across pointer wrap.
- **Reset mid-frame and busy drop:** assert `rst` at T+2 → no `out_vld`, and the next frame reads with `fill` = 0. Separately, a second `in_vld` at T+2 → exactly one `out_vld` at T+4 and `wr_ptr` advanced by 1.
